sprites_priority_mux: RTL and testbench
=======================================

Name: sprites_priority_mux

Overview:
- Parametrised N-channel draw-request/RGB priority multiplexer. It merges any number of object layers (enemies, bombs, player, power-ups) into one drawing request for the top-level objects mux.
- Both outputs are registered with matched latency. Adds a per-channel enable mask, optional frame-rotating priority (fair flicker between overlapping sprites), the winning-channel index, and per-frame overlap statistics for collision debug.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- RGB_W, 8, colour width per channel.
- ROTATE, 0, 0 = fixed priority (channel 0 highest); 1 = priority pointer advances once per frame.
- CNT_W, 16, width of overlap counters.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse at frame start
- chEnable  in  NUM_CH  per-channel enable mask; a 0 bit ignores that channel
- chDR  in  NUM_CH  per-channel drawing request
- chRGB  in  NUM_CH*RGB_W  packed colours; channel i at bits [i*RGB_W +: RGB_W]
- objDR  out  1  merged drawing request
- objRGB  out  RGB_W  selected colour
- objIdx  out  $clog2(NUM_CH)  winning channel index
- overlapDR  out  1  two or more effective requests this pixel
- lastFrameOverlap  out  CNT_W  overlap-pixel count of the previous frame

Behaviour:
- Effective request: act[i] = chDR[i] & chEnable[i]. All logic uses act only.
- Latency: exactly 1 clk from inputs to objDR, objRGB, objIdx and overlapDR. All four update on the same edge.
- Selection order:
  - ROTATE=0: channel 0 first, then 1 .. NUM_CH-1.
  - ROTATE=1: ptr, ptr+1, .. NUM_CH-1, 0, .. ptr-1 (modulo NUM_CH).
  - The winner is the first active channel in that order.
- Any act bit set: objDR<=1, objRGB<=chRGB[winner], objIdx<=winner.
- No act bit set: objDR<=0; objRGB and objIdx hold their previous values.
- overlapDR<=1 when popcount(act)>=2, else 0.
- Priority pointer ptr (internal, $clog2(NUM_CH) bits):
  - Reset value 0.
  - With ROTATE=1, on startOfFrame ptr<=ptr+1, wrapping NUM_CH-1 -> 0. The change takes effect from the next cycle. A pixel arriving in the startOfFrame cycle uses the old ptr.
  - With ROTATE=0, ptr stays 0.
  - Wrap must be correct for non-power-of-2 NUM_CH, e.g. NUM_CH=3: 2 -> 0.
- Overlap counter ovCnt (internal, CNT_W bits):
  - Cycle without startOfFrame: ovCnt increments when popcount(act)>=2, saturating at 2^CNT_W-1.
  - Cycle with startOfFrame: lastFrameOverlap<=ovCnt (value before this cycle's contribution), and ovCnt<=(popcount(act)>=2 ? 1 : 0).
  - lastFrameOverlap changes only on startOfFrame.
- Reset is async, active-low. All of these clear immediately, independent of clk: objDR=0, objRGB=0, objIdx=0, overlapDR=0, lastFrameOverlap=0, ptr=0, ovCnt=0.
- Reset mid-frame discards the partial count. The first startOfFrame after reset publishes the count gathered since reset.
- chEnable may change any cycle and takes effect in the same cycle's selection (it reaches the outputs one clk later).
- Every act bit being 0, including all channels disabled, is treated exactly as no request.
- No combinational path from any input to any output.

Test Plan:
- NUM_CH=4, ROTATE=0, all enabled; chDR=4'b1010, chRGB[1]=8'h1C, chRGB[3]=8'hE0 -> next clk objDR=1, objRGB=8'h1C, objIdx=1, overlapDR=1. Then chDR=0 -> objDR=0, objRGB stays 8'h1C, objIdx stays 1.
- Mask: chDR=4'b0011, chEnable=4'b1110, chRGB[1]=8'h03 -> objRGB=8'h03, objIdx=1, overlapDR=0. Then chEnable=0 -> objDR=0.
- ROTATE=1, NUM_CH=3, chDR=3'b111 held, chRGB={8'h33,8'h22,8'h11} (channels 2,1,0) -> objIdx sequence 0,1,2,0 across 4 consecutive startOfFrame pulses. The change is visible 2 clks after each pulse.
- Overlap stats:
  - Frame with 5 cycles of chDR=4'b0110 and 3 cycles of 4'b0100, then startOfFrame with chDR=0 -> lastFrameOverlap=5, ovCnt restarts at 0.
  - startOfFrame coinciding with an overlap cycle -> next frame starts at 1.
- Saturation: CNT_W=4, 20 overlap cycles then startOfFrame -> lastFrameOverlap=15.
- Async reset asserted mid-frame with objDR=1, ptr=2 -> all outputs 0 immediately without a clk edge. After release, first winner under ROTATE=1 is channel 0.

Source files
------------

// File: rtl/sprites_priority_mux.sv
`default_nettype none
// ============================================================================
// Module      : sprites_priority_mux
// Description : Merges NUM_CH sprite layers into a single drawing request.
//               The first channel with an effective request (chDR & chEnable)
//               wins, searching from channel 0 upward (ROTATE=0) or from a
//               priority pointer that advances once per frame (ROTATE=1).
//               All outputs are registered with one clock of latency. It also
//               flags overlap (two or more requests this pixel) and counts
//               overlap pixels per frame.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk              in   system clock
//   resetN           in   asynchronous active-low reset
//   startOfFrame     in   one-cycle pulse at frame start
//   chEnable         in   [NUM_CH]        per-channel enable mask
//   chDR             in   [NUM_CH]        per-channel drawing request
//   chRGB            in   [NUM_CH*RGB_W]  packed colours, ch i at [i*RGB_W +: RGB_W]
//   objDR            out  merged drawing request
//   objRGB           out  [RGB_W]        winning colour (holds when idle)
//   objIdx           out  [clog2(NUM_CH)] winning channel (holds when idle)
//   overlapDR        out  two or more effective requests this pixel
//   lastFrameOverlap out  [CNT_W]        overlap pixels in the previous frame
// ============================================================================
module sprites_priority_mux #(
  parameter int NUM_CH = 4,
  parameter int RGB_W  = 8,
  parameter int ROTATE = 0,
  parameter int CNT_W  = 16
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        startOfFrame,
  input  logic [NUM_CH-1:0]           chEnable,
  input  logic [NUM_CH-1:0]           chDR,
  input  logic [NUM_CH*RGB_W-1:0]     chRGB,
  output logic                        objDR,
  output logic [RGB_W-1:0]            objRGB,
  output logic [$clog2(NUM_CH)-1:0]   objIdx,
  output logic                        overlapDR,
  output logic [CNT_W-1:0]            lastFrameOverlap
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam logic [IDX_W:0]   C_NUM_CH  = (IDX_W+1)'(NUM_CH);
  localparam logic [IDX_W-1:0] C_LAST_CH = IDX_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  // Registered state
  logic              obj_dr_q,   obj_dr_d;
  logic [RGB_W-1:0]  obj_rgb_q,  obj_rgb_d;
  logic [IDX_W-1:0]  obj_idx_q,  obj_idx_d;
  logic              overlap_q,  overlap_d;
  logic [CNT_W-1:0]  last_ov_q,  last_ov_d;
  logic [CNT_W-1:0]  ov_cnt_q,   ov_cnt_d;
  logic [IDX_W-1:0]  ptr_q,      ptr_d;

  // Combinational helpers
  logic [NUM_CH-1:0] act;
  logic              multi;
  logic              found;
  logic [IDX_W-1:0]  win;
  logic [IDX_W:0]    cand;
  logic [IDX_W-1:0]  cand_idx;
  logic [RGB_W-1:0]  win_rgb;

  always_comb begin
    act = chDR & chEnable;
    // Clearing the lowest set bit leaves something only if two or more bits are set.
    multi = |(act & (act - {{(NUM_CH-1){1'b0}}, 1'b1}));
  end

  // Priority search starting at ptr_q and wrapping modulo NUM_CH. With
  // ROTATE=0 the pointer is pinned at 0, giving plain fixed priority.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    cand     = '0;
    cand_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand >= C_NUM_CH) begin
        cand = cand - C_NUM_CH;
      end
      cand_idx = cand[IDX_W-1:0];
      if (!found && act[cand_idx]) begin
        found = 1'b1;
        win   = cand_idx;
      end
    end
  end

  // Colour mux for the winning channel.
  always_comb begin
    win_rgb = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win == IDX_W'(i)) begin
        win_rgb = chRGB[i*RGB_W +: RGB_W];
      end
    end
  end

  // Next-state for outputs, pointer and overlap statistics.
  always_comb begin
    obj_dr_d  = found;
    obj_rgb_d = found ? win_rgb : obj_rgb_q;
    obj_idx_d = found ? win     : obj_idx_q;
    overlap_d = multi;

    // A new pointer only affects pixels after the startOfFrame cycle.
    ptr_d = ptr_q;
    if ((ROTATE != 0) && startOfFrame) begin
      ptr_d = (ptr_q == C_LAST_CH) ? '0 : ptr_q + IDX_W'(1);
    end

    // On frame start, publish the finished count and seed the new frame
    // with this cycle's own contribution.
    last_ov_d = last_ov_q;
    ov_cnt_d  = ov_cnt_q;
    if (startOfFrame) begin
      last_ov_d = ov_cnt_q;
      ov_cnt_d  = multi ? CNT_W'(1) : '0;
    end else if (multi && (ov_cnt_q != C_CNT_MAX)) begin
      ov_cnt_d  = ov_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      obj_dr_q  <= 1'b0;
      obj_rgb_q <= '0;
      obj_idx_q <= '0;
      overlap_q <= 1'b0;
      last_ov_q <= '0;
      ov_cnt_q  <= '0;
      ptr_q     <= '0;
    end else begin
      obj_dr_q  <= obj_dr_d;
      obj_rgb_q <= obj_rgb_d;
      obj_idx_q <= obj_idx_d;
      overlap_q <= overlap_d;
      last_ov_q <= last_ov_d;
      ov_cnt_q  <= ov_cnt_d;
      ptr_q     <= ptr_d;
    end
  end

  assign objDR            = obj_dr_q;
  assign objRGB           = obj_rgb_q;
  assign objIdx           = obj_idx_q;
  assign overlapDR        = overlap_q;
  assign lastFrameOverlap = last_ov_q;

endmodule
`default_nettype wire

// File: tb/tb_sprites_priority_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprites_priority_mux
// Description : Scoreboard bench for sprites_priority_mux. Three instances:
//               u0 fixed priority NUM_CH=4, u1 rotating NUM_CH=3,
//               u2 fixed NUM_CH=4 with a 4-bit overlap counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprites_priority_mux;

  logic clk;
  logic resetN;
  int   cyc;
  int   total;
  int   bad;
  int   step_id;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- u0 ----------------
  logic        s0_sof;
  logic [3:0]  s0_en, s0_dr;
  logic [31:0] s0_rgb;
  logic        o0_dr, o0_ov;
  logic [7:0]  o0_rgb;
  logic [1:0]  o0_idx;
  logic [15:0] o0_last;

  sprites_priority_mux #(.NUM_CH(4), .RGB_W(8), .ROTATE(0), .CNT_W(16)) u0 (
    .clk(clk), .resetN(resetN), .startOfFrame(s0_sof), .chEnable(s0_en),
    .chDR(s0_dr), .chRGB(s0_rgb), .objDR(o0_dr), .objRGB(o0_rgb),
    .objIdx(o0_idx), .overlapDR(o0_ov), .lastFrameOverlap(o0_last)
  );

  // ---------------- u1 ----------------
  logic        s1_sof;
  logic [2:0]  s1_en, s1_dr;
  logic [23:0] s1_rgb;
  logic        o1_dr, o1_ov;
  logic [7:0]  o1_rgb;
  logic [1:0]  o1_idx;
  logic [15:0] o1_last;

  sprites_priority_mux #(.NUM_CH(3), .RGB_W(8), .ROTATE(1), .CNT_W(16)) u1 (
    .clk(clk), .resetN(resetN), .startOfFrame(s1_sof), .chEnable(s1_en),
    .chDR(s1_dr), .chRGB(s1_rgb), .objDR(o1_dr), .objRGB(o1_rgb),
    .objIdx(o1_idx), .overlapDR(o1_ov), .lastFrameOverlap(o1_last)
  );

  // ---------------- u2 ----------------
  logic        s2_sof;
  logic [3:0]  s2_en, s2_dr;
  logic [31:0] s2_rgb;
  logic        o2_dr, o2_ov;
  logic [7:0]  o2_rgb;
  logic [1:0]  o2_idx;
  logic [3:0]  o2_last;

  sprites_priority_mux #(.NUM_CH(4), .RGB_W(8), .ROTATE(0), .CNT_W(4)) u2 (
    .clk(clk), .resetN(resetN), .startOfFrame(s2_sof), .chEnable(s2_en),
    .chDR(s2_dr), .chRGB(s2_rgb), .objDR(o2_dr), .objRGB(o2_rgb),
    .objIdx(o2_idx), .overlapDR(o2_ov), .lastFrameOverlap(o2_last)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    int         due;
    int         dut;
    int         id;
    logic       dr;
    logic [7:0] rgb;
    int         idx;
    logic       ov;
    int         last;
  } exp_t;

  exp_t q[$];

  task automatic push_exp(input int dut, input logic xdr, input logic [7:0] xrgb,
                          input int xidx, input logic xov, input int xlast);
    exp_t e;
    e.due  = cyc + 1;
    e.dut  = dut;
    e.id   = step_id;
    e.dr   = xdr;
    e.rgb  = xrgb;
    e.idx  = xidx;
    e.ov   = xov;
    e.last = xlast;
    q.push_back(e);
    step_id++;
  endtask

  // Monitor: each negedge, compare every expectation due at this cycle.
  exp_t       m_e;
  logic       m_dr, m_ov;
  logic [7:0] m_rgb;
  int         m_idx, m_last;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      m_e = q.pop_front();
      case (m_e.dut)
        0:       begin m_dr = o0_dr; m_rgb = o0_rgb; m_idx = int'(o0_idx); m_ov = o0_ov; m_last = int'(o0_last); end
        1:       begin m_dr = o1_dr; m_rgb = o1_rgb; m_idx = int'(o1_idx); m_ov = o1_ov; m_last = int'(o1_last); end
        default: begin m_dr = o2_dr; m_rgb = o2_rgb; m_idx = int'(o2_idx); m_ov = o2_ov; m_last = int'(o2_last); end
      endcase
      total++;
      if (m_e.due != cyc) begin
        bad++;
        $display("FAIL late u%0d step%0d: due cycle %0d checked at %0d", m_e.dut, m_e.id, m_e.due, cyc);
      end else if (m_dr !== m_e.dr || m_rgb !== m_e.rgb || m_idx != m_e.idx ||
                   m_ov !== m_e.ov || m_last != m_e.last) begin
        bad++;
        $display("FAIL u%0d step%0d: got dr=%b rgb=%h idx=%0d ov=%b last=%0d want dr=%b rgb=%h idx=%0d ov=%b last=%0d",
                 m_e.dut, m_e.id, m_dr, m_rgb, m_idx, m_ov, m_last,
                 m_e.dr, m_e.rgb, m_e.idx, m_e.ov, m_e.last);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a0(input logic sof, input logic [3:0] en, input logic [3:0] dr,
                    input logic [31:0] rgb, input logic xdr, input logic [7:0] xrgb,
                    input int xidx, input logic xov, input int xlast);
    s0_sof = sof; s0_en = en; s0_dr = dr; s0_rgb = rgb;
    push_exp(0, xdr, xrgb, xidx, xov, xlast);
    tick();
  endtask

  task automatic a1(input logic sof, input logic [2:0] dr, input logic xdr,
                    input logic [7:0] xrgb, input int xidx, input logic xov, input int xlast);
    s1_sof = sof; s1_dr = dr;
    push_exp(1, xdr, xrgb, xidx, xov, xlast);
    tick();
  endtask

  task automatic a2(input logic sof, input logic [3:0] dr, input logic xdr,
                    input logic [7:0] xrgb, input int xidx, input logic xov, input int xlast);
    s2_sof = sof; s2_dr = dr;
    push_exp(2, xdr, xrgb, xidx, xov, xlast);
    tick();
  endtask

  // Immediate check that every output of every instance is zero.
  task automatic check_rst(input int tag);
    logic [2:0] nz;
    nz[0] = o0_dr | o0_ov | (|o0_rgb) | (|o0_idx) | (|o0_last);
    nz[1] = o1_dr | o1_ov | (|o1_rgb) | (|o1_idx) | (|o1_last);
    nz[2] = o2_dr | o2_ov | (|o2_rgb) | (|o2_idx) | (|o2_last);
    for (int d = 0; d < 3; d++) begin
      total++;
      if (nz[d] !== 1'b0) begin
        bad++;
        $display("FAIL reset%0d u%0d: outputs nonzero (u0 %b %h %0d %b %0d | u1 %b %h %0d %b %0d | u2 %b %h %0d %b %0d) want all 0",
                 tag, d, o0_dr, o0_rgb, o0_idx, o0_ov, o0_last,
                 o1_dr, o1_rgb, o1_idx, o1_ov, o1_last,
                 o2_dr, o2_rgb, o2_idx, o2_ov, o2_last);
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    total = 0; bad = 0; step_id = 0;
    resetN = 1'b0;
    s0_sof = 1'b0; s0_en = 4'hF; s0_dr = 4'h0; s0_rgb = 32'h0;
    s1_sof = 1'b0; s1_en = 3'b111; s1_dr = 3'b000; s1_rgb = 24'h332211;
    s2_sof = 1'b0; s2_en = 4'hF; s2_dr = 4'h0; s2_rgb = 32'h44332211;

    repeat (2) @(posedge clk);
    #1;
    check_rst(0);
    resetN = 1'b1;

    // u0: basic selection, hold, mask, fixed priority
    a0(0, 4'hF, 4'b1010, 32'hE000_1C00, 1, 8'h1C, 1, 1, 0);
    a0(0, 4'hF, 4'b0000, 32'hE000_1C00, 0, 8'h1C, 1, 0, 0);
    a0(0, 4'hE, 4'b0011, 32'h0000_0300, 1, 8'h03, 1, 0, 0);
    a0(0, 4'h0, 4'b0011, 32'h0000_0300, 0, 8'h03, 1, 0, 0);
    a0(0, 4'hF, 4'b1111, 32'h4433_2211, 1, 8'h11, 0, 1, 0);
    a0(0, 4'hF, 4'b1000, 32'h4433_2211, 1, 8'h44, 3, 0, 0);
    // First frame start after reset publishes overlaps seen since reset (2).
    a0(1, 4'hF, 4'b0000, 32'h4433_2211, 0, 8'h44, 3, 0, 2);
    // Frame: 5 overlap cycles, 3 single-request cycles.
    for (int i = 0; i < 5; i++) a0(0, 4'hF, 4'b0110, 32'h4433_2211, 1, 8'h22, 1, 1, 2);
    for (int i = 0; i < 3; i++) a0(0, 4'hF, 4'b0100, 32'h4433_2211, 1, 8'h33, 2, 0, 2);
    a0(1, 4'hF, 4'b0000, 32'h4433_2211, 0, 8'h33, 2, 0, 5);
    a0(0, 4'hF, 4'b0000, 32'h4433_2211, 0, 8'h33, 2, 0, 5);
    a0(1, 4'hF, 4'b0000, 32'h4433_2211, 0, 8'h33, 2, 0, 0);
    // Frame start coinciding with overlap seeds the new frame at 1.
    a0(1, 4'hF, 4'b0110, 32'h4433_2211, 1, 8'h22, 1, 1, 0);
    a0(0, 4'hF, 4'b0000, 32'h4433_2211, 0, 8'h22, 1, 0, 0);
    a0(1, 4'hF, 4'b0000, 32'h4433_2211, 0, 8'h22, 1, 0, 1);
    a0(0, 4'hF, 4'b0000, 32'h4433_2211, 0, 8'h22, 1, 0, 1);

    // u2: saturation of a 4-bit counter
    for (int i = 0; i < 20; i++) a2(0, 4'b0011, 1, 8'h11, 0, 1, 0);
    a2(1, 4'b0000, 0, 8'h11, 0, 0, 15);
    a2(1, 4'b0000, 0, 8'h11, 0, 0, 0);

    // u1: rotating priority over three channels, all requesting
    a1(0, 3'b111, 1, 8'h11, 0, 1, 0);
    a1(1, 3'b111, 1, 8'h11, 0, 1, 1);
    a1(0, 3'b111, 1, 8'h22, 1, 1, 1);
    a1(1, 3'b111, 1, 8'h22, 1, 1, 2);
    a1(0, 3'b111, 1, 8'h33, 2, 1, 2);
    a1(1, 3'b111, 1, 8'h33, 2, 1, 2);
    a1(0, 3'b111, 1, 8'h11, 0, 1, 2);
    a1(1, 3'b111, 1, 8'h11, 0, 1, 2);
    a1(1, 3'b111, 1, 8'h22, 1, 1, 1);
    a1(0, 3'b111, 1, 8'h33, 2, 1, 1);

    // Async reset between clock edges with objDR=1 and ptr=2.
    @(negedge clk);
    #1;
    resetN = 1'b0;
    #1;
    check_rst(1);
    @(posedge clk);
    #1;
    resetN = 1'b1;
    a1(0, 3'b111, 1, 8'h11, 0, 1, 0);
    a1(0, 3'b000, 0, 8'h11, 0, 0, 0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
